// File: rtl/iob_reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// iob_reset_sequencer_pkg
// Shared types and helpers for the staged reset sequencer.
//   state_e         : sequencer FSM encoding (3 bits)
//   stg_width()     : width of the stage index / stage_o port
//   lowest_set_bit(): index of the lowest set bit of a 16-bit vector,
//                     returns MAX_STAGES when the vector is all zero
// -----------------------------------------------------------------------------
package iob_reset_sequencer_pkg;

  localparam int MAX_STAGES = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_WAIT = 3'd1,
    WAIT_READY = 3'd2,
    DELAY      = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_e;

  function automatic int stg_width(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

  function automatic logic [4:0] lowest_set_bit(input logic [MAX_STAGES-1:0] v);
    logic [4:0] idx;
    idx = 5'(MAX_STAGES);
    // Scan downwards so the last hit is the lowest index.
    for (int j = MAX_STAGES - 1; j >= 0; j--) begin
      if (v[j]) idx = 5'(j);
    end
    return idx;
  endfunction

endpackage

// File: rtl/iob_reset_sequencer_cnt.sv
// -----------------------------------------------------------------------------
// iob_reset_sequencer_cnt
// Saturating up-counter with a compare output. One instance serves the start
// delay, the per-stage guard delay and the ready-wait timeout; the caller
// selects the compare value.
//   clk_i   : clock
//   arst_i  : asynchronous active-high reset (count -> 0)
//   cke_i   : clock enable, 0 holds the count
//   clr_i   : synchronous clear (wins over en_i)
//   en_i    : count enable
//   cmp_i   : compare value
//   match_o : count equals cmp_i
// -----------------------------------------------------------------------------
module iob_reset_sequencer_cnt
  import iob_reset_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             cke_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic             match_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == cmp_i);

endmodule

// File: rtl/iob_reset_sequencer.sv
// -----------------------------------------------------------------------------
// iob_reset_sequencer
// Releases N_STAGES active-high resets strictly in order. Each stage waits for
// its ready qualifier, then a STAGE_DLY guard, before its reset drops. A
// released stage losing readiness pulls itself and every later stage back
// into reset and resumes sequencing from there. A ready wait longer than
// TIMEOUT parks the sequencer in ERROR until start_i or arst_i.
//   clk_i     : clock
//   arst_i    : asynchronous active-high reset
//   cke_i     : clock enable, 0 freezes all state and outputs
//   start_i   : (re)start the sequence, sampled every cycle
//   ready_i   : per-stage readiness qualifier (synchronous to clk_i)
//   rst_o     : per-stage reset, 1 = held in reset
//   busy_o    : START_WAIT / WAIT_READY / DELAY
//   done_o    : all stages released
//   timeout_o : ready wait exceeded TIMEOUT
//   stage_o   : stage currently being sequenced, N_STAGES when done
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | all resets held, waiting for start_i
// START_WAIT | initial START_DLY cycle delay
// WAIT_READY | waiting for ready_i[k], timeout counter running
// DELAY      | guard delay for stage k, release at the end
// DONE       | all stages released, watching for ready loss
// ERROR      | ready wait timed out, resets frozen
// -----------------------------------------------------------------------------
module iob_reset_sequencer
  import iob_reset_sequencer_pkg::*;
#(
  parameter  int N_STAGES  = 3,
  parameter  int CNT_W     = 16,
  parameter  int START_DLY = 5,
  parameter  int STAGE_DLY = 10,
  parameter  int TIMEOUT   = 65535,
  localparam int STG_W     = stg_width(N_STAGES)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic [N_STAGES-1:0] ready_i,
  output logic [N_STAGES-1:0] rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [STG_W-1:0]    stage_o
);

  // Counter runs 0..N-1 for an N-cycle wait; a STAGE_DLY below 1 behaves as 1.
  localparam logic [CNT_W-1:0] START_CMP   = CNT_W'((START_DLY > 0) ? START_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] STAGE_CMP   = CNT_W'((STAGE_DLY > 1) ? STAGE_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CMP = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [STG_W-1:0] LAST_K      = STG_W'(N_STAGES - 1);
  localparam logic [STG_W-1:0] ALL_K       = STG_W'(N_STAGES);

  state_e              state_q, state_d;
  logic [STG_W-1:0]    k_q, k_d;
  logic [N_STAGES-1:0] rst_q, rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;

  logic                cnt_clr;
  logic                cnt_en;
  logic [CNT_W-1:0]    cnt_cmp;
  logic                cnt_match;

  logic                cur_ready;
  logic [N_STAGES-1:0] loss_vec;
  logic [MAX_STAGES-1:0] loss16;
  logic [4:0]          loss_idx;
  logic                loss_any;

  iob_reset_sequencer_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .cke_i   (cke_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cmp_i   (cnt_cmp),
    .match_o (cnt_match)
  );

  always_comb begin
    cnt_cmp = TIMEOUT_CMP;
    case (state_q)
      START_WAIT: cnt_cmp = START_CMP;
      DELAY:      cnt_cmp = STAGE_CMP;
      default:    cnt_cmp = TIMEOUT_CMP;
    endcase
  end

  // Ready qualifier of the stage being sequenced, and released stages that
  // lost readiness. Unreleased stages always have rst_q=1, so masking with
  // ~rst_q already restricts the check to j<k.
  always_comb begin
    cur_ready = 1'b0;
    for (int j = 0; j < N_STAGES; j++) begin
      if (k_q == STG_W'(j)) cur_ready = ready_i[j];
    end
    loss_vec = '0;
    if ((state_q == WAIT_READY) || (state_q == DELAY) || (state_q == DONE)) begin
      loss_vec = ~rst_q & ~ready_i;
    end
    loss16 = '0;
    for (int j = 0; j < N_STAGES; j++) begin
      loss16[j] = loss_vec[j];
    end
    loss_idx = lowest_set_bit(loss16);
    loss_any = |loss_vec;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rst_d     = rst_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    if (start_i) begin
      rst_d   = '1;
      k_d     = '0;
      cnt_clr = 1'b1;
      if (START_DLY == 0) state_d = WAIT_READY;
      else                state_d = START_WAIT;
    end else if (loss_any) begin
      // Re-assert the lowest lost stage and everything above it.
      for (int j = 0; j < N_STAGES; j++) begin
        if (5'(j) >= loss_idx) rst_d[j] = 1'b1;
      end
      k_d     = STG_W'(loss_idx);
      cnt_clr = 1'b1;
      state_d = WAIT_READY;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        START_WAIT: begin
          if (cnt_match) begin
            state_d = WAIT_READY;
            k_d     = '0;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        WAIT_READY: begin
          if (cur_ready) begin
            state_d = DELAY;
            cnt_clr = 1'b1;
          end else if ((TIMEOUT != 0) && cnt_match) begin
            state_d = ERROR;
          end else begin
            cnt_en = 1'b1;
          end
        end
        DELAY: begin
          if (!cur_ready) begin
            state_d = WAIT_READY;
            cnt_clr = 1'b1;
          end else if (cnt_match) begin
            for (int j = 0; j < N_STAGES; j++) begin
              if (k_q == STG_W'(j)) rst_d[j] = 1'b0;
            end
            cnt_clr = 1'b1;
            if (k_q == LAST_K) begin
              state_d = DONE;
              k_d     = ALL_K;
            end else begin
              state_d = WAIT_READY;
              k_d     = k_q + STG_W'(1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end

    busy_d    = (state_d == START_WAIT) || (state_d == WAIT_READY) || (state_d == DELAY);
    done_d    = (state_d == DONE);
    timeout_d = (state_d == ERROR);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      k_q       <= '0;
      rst_q     <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      k_q       <= k_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign rst_o     = rst_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign stage_o   = k_q;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_iob_reset_sequencer
// Two sequencers: dut_a with default parameters, dut_b with TIMEOUT=20.
// Expected output values are queued with the edge index (relative to the
// edge that sampled start_i or the stimulus change) at which they must hold.
// -----------------------------------------------------------------------------
module tb_iob_reset_sequencer;

  localparam int S_RST   = 0;
  localparam int S_DONE  = 1;
  localparam int S_BUSY  = 2;
  localparam int S_STAGE = 3;
  localparam int S_TOB   = 4;
  localparam int S_RSTB  = 5;

  logic       clk = 1'b0;
  logic       arst, cke, start_a, start_b;
  logic [2:0] ready_a, ready_b, rst_a, rst_b;
  logic       busy_a, done_a, to_a, busy_b, done_b, to_b;
  logic [1:0] stage_a, stage_b;

  always #5 clk = ~clk;

  iob_reset_sequencer dut_a (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .start_i(start_a), .ready_i(ready_a),
    .rst_o(rst_a), .busy_o(busy_a), .done_o(done_a), .timeout_o(to_a), .stage_o(stage_a)
  );

  iob_reset_sequencer #(.TIMEOUT(20)) dut_b (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .start_i(start_b), .ready_i(ready_b),
    .rst_o(rst_b), .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b), .stage_o(stage_b)
  );

  typedef struct {
    int    ed;
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   e = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_RST:   return 32'(rst_a);
      S_DONE:  return 32'(done_a);
      S_BUSY:  return 32'(busy_a);
      S_STAGE: return 32'(stage_a);
      S_TOB:   return 32'(to_b);
      S_RSTB:  return 32'(rst_b);
      default: return 32'hdead;
    endcase
  endfunction

  task automatic want(input int ed, input string tag, input int sig, input int val);
    exp_t x;
    x.ed = ed; x.tag = tag; x.sig = sig; x.val = val;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].ed == e) begin
        check(sb[i].tag, observe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    e = 0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    e = 0;
  endtask

  initial begin
    arst = 1'b1; cke = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ready_a = 3'b111; ready_b = 3'b110;
    #3;
    check("reset_rst",     rst_a,   3'b111);
    check("reset_busy",    busy_a,  0);
    check("reset_done",    done_a,  0);
    check("reset_timeout", to_a,    0);
    check("reset_stage",   stage_a, 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal sequence
    pulse_start_a();
    want(1,  "nom_busy_e1",  S_BUSY,  1);
    want(15, "nom_rst_e15",  S_RST,   3'b111);
    want(16, "nom_rst_e16",  S_RST,   3'b110);
    want(17, "nom_stage_e17", S_STAGE, 1);
    want(26, "nom_rst_e26",  S_RST,   3'b110);
    want(27, "nom_rst_e27",  S_RST,   3'b100);
    want(37, "nom_rst_e37",  S_RST,   3'b100);
    want(37, "nom_done_e37", S_DONE,  0);
    want(37, "nom_busy_e37", S_BUSY,  1);
    want(38, "nom_rst_e38",  S_RST,   3'b000);
    want(38, "nom_done_e38", S_DONE,  1);
    want(38, "nom_busy_e38", S_BUSY,  0);
    want(38, "nom_stage_e38", S_STAGE, 3);
    run_to(40);

    // Ready gating on stage 1
    ready_a = 3'b101;
    pulse_start_a();
    want(1,  "gate_rst_e1",    S_RST,   3'b111);
    want(16, "gate_rst_e16",   S_RST,   3'b110);
    want(17, "gate_stage_e17", S_STAGE, 1);
    want(35, "gate_stage_e35", S_STAGE, 1);
    want(50, "gate_stage_e50", S_STAGE, 1);
    want(50, "gate_rst_e50",   S_RST,   3'b110);
    run_to(50);
    ready_a = 3'b111;
    want(60, "gate_rst_e60",  S_RST,  3'b110);
    want(61, "gate_rst_e61",  S_RST,  3'b100);
    want(71, "gate_rst_e71",  S_RST,  3'b100);
    want(72, "gate_rst_e72",  S_RST,  3'b000);
    want(72, "gate_done_e72", S_DONE, 1);
    run_to(73);

    // Ready loss in DONE
    e = 0;
    ready_a = 3'b101;
    want(1,  "loss_rst_l1",   S_RST,   3'b110);
    want(1,  "loss_done_l1",  S_DONE,  0);
    want(1,  "loss_stage_l1", S_STAGE, 1);
    run_to(3);
    ready_a = 3'b111;
    want(13, "loss_rst_l13",  S_RST,  3'b110);
    want(14, "loss_rst_l14",  S_RST,  3'b100);
    want(24, "loss_rst_l24",  S_RST,  3'b100);
    want(25, "loss_rst_l25",  S_RST,  3'b000);
    want(25, "loss_done_l25", S_DONE, 1);
    run_to(26);

    // Restart and async reset in the middle of stage 1's DELAY
    pulse_start_a();
    want(16, "pre_rst_e16", S_RST, 3'b110);
    run_to(20);
    pulse_start_a();
    check("restart_rst",   rst_a,   3'b111);
    check("restart_stage", stage_a, 0);
    want(15, "restart_rst_r15",   S_RST,   3'b111);
    want(16, "restart_rst_r16",   S_RST,   3'b110);
    want(17, "restart_stage_r17", S_STAGE, 1);
    want(21, "restart_rst_r21",   S_RST,   3'b110);
    run_to(21);
    arst = 1'b1;
    #2;
    check("arst_rst",     rst_a,   3'b111);
    check("arst_busy",    busy_a,  0);
    check("arst_done",    done_a,  0);
    check("arst_stage",   stage_a, 0);
    check("arst_timeout", to_a,    0);
    arst = 1'b0;
    @(posedge clk);
    #1;

    // Clock enable low for 7 cycles during START_WAIT
    pulse_start_a();
    run_to(2);
    cke = 1'b0;
    want(5,  "cke_busy_e5",  S_BUSY, 1);
    want(9,  "cke_rst_e9",   S_RST,  3'b111);
    run_to(9);
    cke = 1'b1;
    want(22, "cke_rst_e22",  S_RST,  3'b111);
    want(23, "cke_rst_e23",  S_RST,  3'b110);
    want(33, "cke_rst_e33",  S_RST,  3'b110);
    want(34, "cke_rst_e34",  S_RST,  3'b100);
    want(44, "cke_rst_e44",  S_RST,  3'b100);
    want(45, "cke_rst_e45",  S_RST,  3'b000);
    want(45, "cke_done_e45", S_DONE, 1);
    run_to(46);

    // Timeout on dut_b (TIMEOUT=20, stage 0 never ready)
    pulse_start_b();
    want(24, "to_e24",     S_TOB,  0);
    want(26, "to_e26",     S_TOB,  1);
    want(26, "to_rst_e26", S_RSTB, 3'b111);
    want(40, "to_e40",     S_TOB,  1);
    want(40, "to_rst_e40", S_RSTB, 3'b111);
    run_to(40);
    pulse_start_b();
    check("to_clear", to_b, 0);
    ready_b = 3'b111;
    want(15, "to_restart_r15", S_RSTB, 3'b111);
    want(16, "to_restart_r16", S_RSTB, 3'b110);
    run_to(16);

    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
